// File: rtl/ifu_pkg.sv
// Shared types and helpers for the line-fetch instruction fetch unit.
package ifu_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_LOOKUP = 2'd1,
    IFU_REFILL = 2'd2
  } ifu_state_e;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_MAX_W = 64;

  // Word-within-line field width.
  function automatic int unsigned off_w(input int unsigned line_words);
    return unsigned'($clog2(line_words));
  endfunction

  // Line index field width.
  function automatic int unsigned idx_w(input int unsigned num_lines);
    return unsigned'($clog2(num_lines));
  endfunction

  // Tag field width: word address bits left over after index and offset.
  function automatic int unsigned tag_w(input int unsigned num_lines,
                                        input int unsigned line_words);
    return 30 - off_w(line_words) - idx_w(num_lines);
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (val >= max_val) ? val : val + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache storage: valid/tag/data arrays with a
// registered read port, a word write port, line-valid set and flush-all.
module icache_dm
  import ifu_pkg::*;
#(
  parameter int unsigned  NUM_LINES  = 16,
  parameter int unsigned  LINE_WORDS = 4,
  localparam int unsigned OFF_W      = off_w(LINE_WORDS),
  localparam int unsigned IDX_W      = idx_w(NUM_LINES),
  localparam int unsigned TAG_W      = tag_w(NUM_LINES, LINE_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  // Registered read port
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_index,
  input  logic [OFF_W-1:0] i_rd_word,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  // Word write port
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_index,
  input  logic [OFF_W-1:0] i_wr_word,
  input  logic [31:0]      i_wr_data,
  // Line tag write + valid set
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_index,
  input  logic [TAG_W-1:0] i_set_tag,
  // Single-line invalidate and flush-all
  input  logic             i_inv_en,
  input  logic [IDX_W-1:0] i_inv_index,
  input  logic             i_flush_all
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
  logic                 r_rd_valid;
  logic [TAG_W-1:0]     r_rd_tag;
  logic [31:0]          r_rd_data;
  logic [IDX_W+OFF_W-1:0] w_rd_addr;
  logic [IDX_W+OFF_W-1:0] w_wr_addr;

  assign w_rd_addr = {i_rd_index, i_rd_word};
  assign w_wr_addr = {i_wr_index, i_wr_word};

  // Valid bits: flush-all overrides, then set wins over invalidate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_flush_all) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) r_valid[i_inv_index] <= 1'b0;
      if (i_set_en) r_valid[i_set_index] <= 1'b1;
    end
  end

  // Registered valid read; a same-cycle flush must force a miss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_valid <= r_valid[i_rd_index] & ~i_flush_all;
    end
  end

  // Tag/data storage and their registered reads; contents are not reset.
  always_ff @(posedge clock) begin
    if (i_rd_en) begin
      r_rd_tag  <= r_tag[i_rd_index];
      r_rd_data <= r_data[w_rd_addr];
    end
    if (i_set_en) r_tag[i_set_index] <= i_set_tag;
    if (i_wr_en)  r_data[w_wr_addr]  <= i_wr_data;
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_tag;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/ifu_line_fetch.sv
// Instruction fetch unit: serves 32-bit fetches from a direct-mapped icache and
// refills whole lines over the word-wide io bus. Holds the FSM, beat counter,
// requested-word capture, deferred flush and saturating hit/miss counters.
module ifu_line_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 32  // at most SAT_MAX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             reqValid,
  output logic             respValid,
  output logic [31:0]      inst,
  input  logic             flush,
  output logic             busy,
  output logic [31:0]      io_addr,
  output logic             io_reqValid,
  input  logic             io_respValid,
  input  logic [31:0]      io_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned      OFF_W     = off_w(LINE_WORDS);
  localparam int unsigned      IDX_W     = idx_w(NUM_LINES);
  localparam int unsigned      TAG_W     = tag_w(NUM_LINES, LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  ifu_state_e       r_state, w_state_next;
  logic [29:0]      r_pc;          // latched word address of the fetch
  logic [OFF_W-1:0] r_beat, w_beat_next;
  logic [31:0]      r_word_buf;    // requested word if it arrived before the last beat
  logic             r_flush_pend;
  logic             r_resp_valid, w_resp_valid_next;
  logic [31:0]      r_inst, w_inst_next;
  logic [CNT_W-1:0] r_hit_count, r_miss_count;

  logic             w_accept, w_hit, w_miss, w_capture;
  logic             w_wr_en, w_set_en, w_inv_en, w_flush_all;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_data;
  logic [OFF_W-1:0] w_word;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_unused;

  // Byte offset within the word never matters for 32-bit fetches.
  assign w_unused = ^pc[1:0];

  assign w_word  = r_pc[OFF_W-1:0];
  assign w_index = r_pc[OFF_W+IDX_W-1:OFF_W];
  assign w_tag   = r_pc[29:OFF_W+IDX_W];

  // A flush seen while busy is applied on the first IDLE cycle, after the
  // in-flight line has been written, so that line is dropped too.
  assign w_flush_all = (r_state == IFU_IDLE) && (flush || r_flush_pend);

  icache_dm #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_icache (
    .clock       (clock),
    .reset       (reset),
    .i_rd_en     (w_accept),
    .i_rd_index  (pc[OFF_W+IDX_W+1:OFF_W+2]),
    .i_rd_word   (pc[OFF_W+1:2]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_wr_en),
    .i_wr_index  (w_index),
    .i_wr_word   (r_beat),
    .i_wr_data   (io_rdata),
    .i_set_en    (w_set_en),
    .i_set_index (w_index),
    .i_set_tag   (w_tag),
    .i_inv_en    (w_inv_en),
    .i_inv_index (w_index),
    .i_flush_all (w_flush_all)
  );

  // Next-state, cache control and registered-output next values.
  always_comb begin
    w_state_next      = r_state;
    w_beat_next       = r_beat;
    w_accept          = 1'b0;
    w_hit             = 1'b0;
    w_miss            = 1'b0;
    w_capture         = 1'b0;
    w_wr_en           = 1'b0;
    w_set_en          = 1'b0;
    w_inv_en          = 1'b0;
    w_resp_valid_next = 1'b0;
    w_inst_next       = '0;
    unique case (r_state)
      IFU_IDLE: begin
        // The response cycle itself does not take a new request.
        if (reqValid && !r_resp_valid) begin
          w_accept     = 1'b1;
          w_state_next = IFU_LOOKUP;
        end
      end
      IFU_LOOKUP: begin
        if (w_rd_valid && (w_rd_tag == w_tag)) begin
          w_hit             = 1'b1;
          w_resp_valid_next = 1'b1;
          w_inst_next       = w_rd_data;
          w_state_next      = IFU_IDLE;
        end else begin
          w_miss       = 1'b1;
          w_inv_en     = 1'b1;
          w_beat_next  = '0;
          w_state_next = IFU_REFILL;
        end
      end
      IFU_REFILL: begin
        if (io_respValid) begin
          w_wr_en     = 1'b1;
          w_beat_next = r_beat + 1'b1;
          w_capture   = (r_beat == w_word);
          if (r_beat == LAST_BEAT) begin
            w_set_en          = 1'b1;
            w_resp_valid_next = 1'b1;
            w_inst_next       = (r_beat == w_word) ? io_rdata : r_word_buf;
            w_state_next      = IFU_IDLE;
          end
        end
      end
      default: w_state_next = IFU_IDLE;
    endcase
  end

  // FSM, datapath and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IFU_IDLE;
      r_pc         <= '0;
      r_beat       <= '0;
      r_word_buf   <= '0;
      r_flush_pend <= 1'b0;
      r_resp_valid <= 1'b0;
      r_inst       <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_beat       <= w_beat_next;
      r_resp_valid <= w_resp_valid_next;
      r_inst       <= w_inst_next;
      if (w_accept)  r_pc       <= pc[31:2];
      if (w_capture) r_word_buf <= io_rdata;
      if (r_state == IFU_IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end
      if (w_hit)  r_hit_count  <= CNT_W'(sat_inc(SAT_MAX_W'(r_hit_count), CNT_W));
      if (w_miss) r_miss_count <= CNT_W'(sat_inc(SAT_MAX_W'(r_miss_count), CNT_W));
    end
  end

  assign respValid   = r_resp_valid;
  assign inst        = r_inst;
  assign busy        = (r_state != IFU_IDLE);
  assign io_reqValid = (r_state == IFU_REFILL);
  assign io_addr     = (r_state == IFU_REFILL) ? {r_pc[29:OFF_W], r_beat, 2'b00} : '0;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_ifu_line_fetch.sv
// Directed bench for ifu_line_fetch with a scoreboard of expected instructions,
// a stalling bus responder backed by a memory function, and a hit/miss model.
module tb_ifu_line_fetch;

  localparam int unsigned NL = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 4;  // small so saturation is reachable
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam int M_PLAIN     = 0;
  localparam int M_TOGGLE    = 1;
  localparam int M_FLUSH_MID = 2;
  localparam int M_FLUSH_REQ = 3;
  localparam int M_HOLD      = 4;

  logic          clock;
  logic          reset;
  logic [31:0]   pc;
  logic          reqValid;
  logic          respValid;
  logic [31:0]   inst;
  logic          flush;
  logic          busy;
  logic [31:0]   io_addr;
  logic          io_reqValid;
  logic          io_respValid;
  logic [31:0]   io_rdata;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_beats  = 0;
  int            max_stall = 0;
  logic [31:0]   q_exp[$];
  logic [31:0]   q_addr[$];
  bit            m_valid[NL];
  logic [23:0]   m_tag[NL];
  logic [CW-1:0] exp_hit;
  logic [CW-1:0] exp_miss;

  ifu_line_fetch #(
    .NUM_LINES  (NL),
    .LINE_WORDS (LW),
    .CNT_W      (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .reqValid     (reqValid),
    .respValid    (respValid),
    .inst         (inst),
    .flush        (flush),
    .busy         (busy),
    .io_addr      (io_addr),
    .io_reqValid  (io_reqValid),
    .io_respValid (io_respValid),
    .io_rdata     (io_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h required 0x%08h", name, obs, req);
    end
  endtask

  // Bus responder: 0..max_stall idle cycles per beat, data from mem_word.
  initial begin : bus_model
    int stall_cnt;
    stall_cnt    = -1;
    io_respValid = 1'b0;
    io_rdata     = '0;
    forever begin
      @(negedge clock);
      io_respValid = 1'b0;
      io_rdata     = '0;
      if (io_reqValid) begin
        if (stall_cnt < 0)
          stall_cnt = (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
        if (stall_cnt == 0) begin
          io_respValid = 1'b1;
          io_rdata     = mem_word(io_addr);
          q_addr.push_back(io_addr);
          n_beats++;
          stall_cnt = -1;
        end else begin
          stall_cnt--;
        end
      end else begin
        stall_cnt = -1;
      end
    end
  end

  // One fetch: push the expected word, run until respValid, check the result.
  task automatic fetch(input logic [31:0] a, input int mode, input string name);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          hit;
    bit          got;
    bit          flushed;
    int          lat;
    int          beats0;
    idx = a[7:4];
    tg  = a[31:8];
    if (mode == M_FLUSH_REQ)
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      if (exp_hit != CNT_MAX) exp_hit++;
    end else begin
      if (exp_miss != CNT_MAX) exp_miss++;
    end
    q_exp.push_back(mem_word({a[31:2], 2'b00}));
    beats0  = n_beats;
    got     = 1'b0;
    flushed = 1'b0;
    lat     = 0;
    @(negedge clock);
    pc       = a;
    reqValid = 1'b1;
    flush    = (mode == M_FLUSH_REQ);
    while (!got && lat < 400) begin
      @(negedge clock);
      lat++;
      flush = 1'b0;
      pc    = $urandom();
      if (respValid) begin
        got = 1'b1;
        chk({name, "_inst"}, inst, q_exp.pop_front());
        reqValid = (mode == M_HOLD);
      end else begin
        reqValid = (mode == M_TOGGLE) ? 1'($urandom_range(1, 0)) : 1'b0;
        if (mode == M_FLUSH_MID && io_reqValid && !flushed) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end
      end
    end
    chk({name, "_resp"}, 32'(got), 32'd1);
    if (!got && q_exp.size() > 0) void'(q_exp.pop_front());
    if (mode == M_HOLD) begin
      @(negedge clock);
      chk({name, "_b2b_ignored"}, 32'(busy), 32'd0);
      reqValid = 1'b0;
      for (int k = 0; k < 400 && busy; k++) @(negedge clock);
    end
    if (got && hit) chk({name, "_lat"}, 32'(lat), 32'd2);
    else if (got && max_stall == 0) chk({name, "_lat"}, 32'(lat), 32'(2 + LW));
    chk({name, "_beats"}, 32'(n_beats - beats0), hit ? 32'd0 : 32'(LW));
    chk({name, "_hits"}, 32'(hit_count), 32'(exp_hit));
    chk({name, "_misses"}, 32'(miss_count), 32'(exp_miss));
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    if (mode == M_FLUSH_MID && flushed)
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  initial begin : main
    bit found;
    pc       = '0;
    reqValid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    exp_hit  = '0;
    exp_miss = '0;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    repeat (3) @(negedge clock);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_io_reqValid", 32'(io_reqValid), 32'd0);
    chk("rst_io_addr", io_addr, 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    reset = 1'b0;

    // Cold fetch: four beats in order from the line base.
    q_addr.delete();
    fetch(32'h8000_0004, M_PLAIN, "t1_cold");
    chk("t1_nbeats", 32'(q_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), (i < q_addr.size()) ? q_addr[i] : 32'hDEAD_BEEF,
          32'h8000_0000 + 32'(4 * i));

    // Hit in the same line; a request during the response cycle is dropped.
    fetch(32'h8000_0008, M_HOLD, "t2_hit");

    // Conflicting tags on index 0; flush with the first request forces a miss.
    fetch(32'h8000_0000, M_FLUSH_REQ, "t3_a");
    fetch(32'h8000_0100, M_PLAIN, "t3_b");
    fetch(32'h8000_0000, M_PLAIN, "t3_a_again");

    // Flush pulse during a refill: data still correct, line dropped afterwards.
    fetch(32'h8000_0100, M_PLAIN, "t4_evict");
    fetch(32'h8000_0000, M_FLUSH_MID, "t4_flush_mid");
    fetch(32'h8000_0000, M_PLAIN, "t4_after_flush");

    // Reset at beat 2 of a refill.
    @(negedge clock);
    pc       = 32'h8000_0048;
    reqValid = 1'b1;
    @(negedge clock);
    reqValid = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clock);
      if (io_reqValid && io_addr[3:2] == 2'd2) found = 1'b1;
    end
    chk("t5_found_beat2", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_respValid", 32'(respValid), 32'd0);
    chk("t5_inst", inst, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_io_reqValid", 32'(io_reqValid), 32'd0);
    chk("t5_io_addr", io_addr, 32'd0);
    chk("t5_misses", 32'(miss_count), 32'd0);
    reset    = 1'b0;
    exp_hit  = '0;
    exp_miss = '0;
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    q_addr.delete();
    fetch(32'h8000_0048, M_PLAIN, "t5_refetch");
    chk("t5_nbeats", 32'(q_addr.size()), 32'd4);
    chk("t5_first_beat", (q_addr.size() > 0) ? q_addr[0] : 32'hDEAD_BEEF, 32'h8000_0040);

    // Random bus stalls, reqValid/pc toggled while busy, random byte offsets.
    max_stall = 5;
    for (int n = 0; n < 24; n++)
      fetch(32'h8000_0000 + 32'($urandom_range(511, 0)), M_TOGGLE,
            $sformatf("t6_rand%0d", n));

    // Enough hits to pin the hit counter at all-ones.
    max_stall = 0;
    for (int n = 0; n < 18; n++) fetch(32'h8000_0010, M_PLAIN, $sformatf("t6_sat%0d", n));
    chk("t6_hit_saturated", 32'(hit_count), 32'(CNT_MAX));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
